// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU configuration codes and the EX pipeline register layout
// for the decode-to-execute boundary.
package id_ex_stage_pkg;

    localparam int ALU_CONF_W = 5;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int SHAMT_W    = 5;

    typedef enum logic [ALU_CONF_W-1:0] {
        ALU_ADD  = 5'b00000,
        ALU_OR   = 5'b00001,
        ALU_AND  = 5'b00010,
        ALU_ANDN = 5'b00011,
        ALU_SUB  = 5'b00110,
        ALU_SLT  = 5'b00111,
        ALU_NOR  = 5'b01100,
        ALU_XOR  = 5'b01101,
        ALU_SRL  = 5'b10000,
        ALU_SRA  = 5'b11000,
        ALU_SLL  = 5'b11001
    } alu_conf_e;

    typedef struct packed {
        logic                  valid;
        logic [ALU_CONF_W-1:0] alu_conf;
        logic                  sign;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm;
        logic [SHAMT_W-1:0]    shamt;
        logic [REG_ADDR_W-1:0] rs_addr;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  src_imm;
        logic                  src_shamt;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } ex_reg_t;

    // A bubble is simply the all-zero register image.
    localparam ex_reg_t EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding for one source register: EX/MEM beats MEM/WB, and
// register 0 always passes its registered value.
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0]     reg_data,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic [DATA_W-1:0]     fwd_data
);

    always_comb begin
        fwd_data = reg_data;
        if (src_addr != '0) begin
            if (exmem_reg_write && (exmem_rd == src_addr)) begin
                fwd_data = exmem_result;
            end else if (memwb_reg_write && (memwb_rd == src_addr)) begin
                fwd_data = memwb_result;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, load-use detection and
// combinational operand forwarding into the ALU inputs.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [ALU_CONF_W-1:0] id_alu_conf,
    input  logic                  id_sign,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [SHAMT_W-1:0]    id_shamt,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_src_imm,
    input  logic                  id_src_shamt,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic [ALU_CONF_W-1:0] ex_alu_conf,
    output logic                  ex_sign,
    output logic [DATA_W-1:0]     ex_in1,
    output logic [DATA_W-1:0]     ex_in2,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  load_use_hazard
);

    ex_reg_t ex_reg;
    ex_reg_t ex_next;
    ex_reg_t id_fields;

    logic [REG_ADDR_W-1:0] src_addr [2];
    logic [DATA_W-1:0]     src_data [2];
    logic [DATA_W-1:0]     fwd_data [2];

    always_comb begin
        id_fields = '{
            valid:     1'b1,
            alu_conf:  id_alu_conf,
            sign:      id_sign,
            rs_data:   id_rs_data,
            rt_data:   id_rt_data,
            imm:       id_imm,
            shamt:     id_shamt,
            rs_addr:   id_rs_addr,
            rt_addr:   id_rt_addr,
            rd_addr:   id_rd_addr,
            src_imm:   id_src_imm,
            src_shamt: id_src_shamt,
            reg_write: id_reg_write,
            mem_read:  id_mem_read,
            mem_write: id_mem_write
        };
    end

    assign load_use_hazard = id_valid && ex_reg.valid && ex_reg.mem_read &&
                             (ex_reg.rd_addr != '0) &&
                             ((ex_reg.rd_addr == id_rs_addr) || (ex_reg.rd_addr == id_rt_addr));

    // Flush outranks stall; a hazard or an invalid decode slot both become a bubble.
    always_comb begin
        ex_next = ex_reg;
        if (flush) begin
            ex_next = EX_BUBBLE;
        end else if (stall) begin
            ex_next = ex_reg;
        end else if (load_use_hazard || !id_valid) begin
            ex_next = EX_BUBBLE;
        end else begin
            ex_next = id_fields;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg <= EX_BUBBLE;
        end else begin
            ex_reg <= ex_next;
        end
    end

    assign src_addr[0] = ex_reg.rs_addr;
    assign src_addr[1] = ex_reg.rt_addr;
    assign src_data[0] = ex_reg.rs_data;
    assign src_data[1] = ex_reg.rt_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_mux u_fwd_mux (
                .src_addr        (src_addr[gi]),
                .reg_data        (src_data[gi]),
                .exmem_reg_write (exmem_reg_write),
                .exmem_rd        (exmem_rd),
                .exmem_result    (exmem_result),
                .memwb_reg_write (memwb_reg_write),
                .memwb_rd        (memwb_rd),
                .memwb_result    (memwb_result),
                .fwd_data        (fwd_data[gi])
            );
        end
    endgenerate

    // Shift amount is presented in bits 10:6 of the first ALU operand.
    assign ex_in1 = ex_reg.src_shamt
                  ? {{(DATA_W-SHAMT_W-6){1'b0}}, ex_reg.shamt, 6'b0}
                  : fwd_data[0];
    assign ex_in2        = ex_reg.src_imm ? ex_reg.imm : fwd_data[1];
    assign ex_store_data = fwd_data[1];

    assign ex_alu_conf  = ex_reg.alu_conf;
    assign ex_sign      = ex_reg.sign;
    assign ex_valid     = ex_reg.valid;
    assign ex_rd_addr   = ex_reg.rd_addr;
    assign ex_reg_write = ex_reg.reg_write;
    assign ex_mem_read  = ex_reg.mem_read;
    assign ex_mem_write = ex_reg.mem_write;

endmodule
